debug_tx_serializer: RTL and testbench
======================================

# debug_tx_serializer

Transmit side of the debug link. It takes the 32-bit `result` word and the 2-bit `size` code produced by the debugger decoder and sends `size+1` bytes, least-significant byte first, as standard 8N1 UART frames on a single serial line. It sits directly downstream of the decoder, between it and the board TX pin, and contains the bit-level UART transmitter.

## Interface
Parameters:
- `CLKS_PER_BIT`, 434: clock cycles per UART bit (50 MHz / 115200). Must be ≥ 2.

Ports:
- `clk` input 1: single system clock. All state changes on the rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: request to send. Sampled only in IDLE.
- `result` input 32: data word from the decoder. Captured on an accepted `start`.
- `size` input 2: byte count minus one (00=1 byte … 11=4 bytes). Captured on an accepted `start`.
- `busy` output 1: high from the edge that accepts `start` until the last stop bit completes.
- `done` output 1: one-cycle pulse when the last stop bit completes.
- `tx` output 1: serial line, registered, idles high.

## Operation
- Reset values: `tx`=1, `busy`=0, `done`=0. State is IDLE. Byte counter, bit counter and baud counter are 0.
- FSM states:
  - IDLE: `tx`=1.
  - START_BIT: `tx`=0.
  - DATA: `tx`=current bit. Bits go out LSB first.
  - STOP_BIT: `tx`=1.
- IDLE → START_BIT: taken when `start`=1.
  - Latch `result` into a 32-bit shift register.
  - Latch `size` into the bytes-remaining counter.
  - Set `busy`=1.
- START_BIT → DATA: taken after `CLKS_PER_BIT` cycles.
- DATA: each bit is held `CLKS_PER_BIT` cycles. After bit 7, go to STOP_BIT.
- STOP_BIT, after `CLKS_PER_BIT` cycles:
  - If bytes remaining ≠ 0: shift the word right by 8, decrement the counter, go to START_BIT. There is no idle gap between frames.
  - Otherwise: go to IDLE, `busy`=0, `done`=1 for that one cycle.
- Byte order: `result[7:0]`, then `[15:8]`, then `[23:16]`, then `[31:24]`. The sequence is truncated at `size+1` bytes.
- Input stability: `start` while busy is ignored. `result` and `size` changes while busy have no effect.
- Reset mid-operation: the frame is abandoned and no completion is signalled. On the next edge, `tx`=1, `busy`=0, state is IDLE, and `done` stays 0.
- Baud counter:
  - Width is `$clog2(CLKS_PER_BIT)`.
  - Counts 0..`CLKS_PER_BIT`-1, then wraps to 0 on each bit boundary.
  - Cleared when `start` is accepted.

## Timing
- `start` is sampled high at edge k in IDLE.
  - `busy`=1 and `tx`=0 are visible from edge k.
  - The start bit occupies cycles k..k+`CLKS_PER_BIT`-1.
- Each frame is 10 bits, i.e. 10·`CLKS_PER_BIT` cycles. Frames are back-to-back.
- `done` pulses, and `busy` falls, at edge k + (size+1)·10·`CLKS_PER_BIT`.
- On the `done` edge, state is already IDLE.
  - A `start` sampled high on that same edge is not accepted; it is accepted on the next edge.
  - Minimum spacing between the `done` edge and the next start bit is therefore 1 cycle.
- `done` never coincides with `busy`=1.
- `tx` is glitch-free: it comes straight from a flop, with no combinational path from inputs.

## Test plan
- **Single byte.** `CLKS_PER_BIT`=4, `result`=0x000000A5, `size`=00, `start` pulse.
  - `tx` = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles.
  - `done` pulses exactly 40 cycles after the accepting edge.
- **Four bytes.** `CLKS_PER_BIT`=4, `result`=0x12345678, `size`=11.
  - Frames carry 0x78, 0x56, 0x34, 0x12 in that order, with no gaps.
  - `busy` is high for 160 cycles, then `done` pulses once.
- **Two bytes, input change mid-send.** `result`=0xDEADBEEF, `size`=01.
  - Only 0xEF and 0xBE are sent, and `done` follows at 80 cycles.
  - Changing `result` to 0 after acceptance does not alter the bytes sent.
- **Start while busy.** Pulse `start` with new data mid-frame of a 1-byte send.
  - The pulse is ignored: still 40 cycles total, one `done`, and `tx` high afterwards.
- **Reset mid-frame.** Assert `reset` during DATA bit 3 of a 4-byte send.
  - Next edge: `tx`=1, `busy`=0, no `done` ever.
  - A subsequent `start` sends a correct fresh frame.
- **Back-to-back request.** Hold `start` high continuously with `size`=00.
  - Consecutive 40-cycle frames are separated by exactly 1 idle cycle (`tx`=1) at each `done`.

Source files
------------

// File: rtl/debug_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : debug_tx_serializer
//  Description : Sends size+1 bytes of a 32-bit word, LSB byte first, as
//                back-to-back 8N1 UART frames on a registered tx line.
//  Revision    : 1.0 - initial release
// ============================================================================
module debug_tx_serializer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] result,
    input  logic [1:0]  size,
    output logic        busy,
    output logic        done,
    output logic        tx
);

    localparam int c_baud_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_baud_w-1:0] c_baud_max = c_baud_w'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t              r_state, w_state_next;
    logic [c_baud_w-1:0] r_baud,  w_baud_next;
    logic [2:0]          r_bit,   w_bit_next;
    logic [1:0]          r_bytes, w_bytes_next;
    logic [31:0]         r_shift, w_shift_next;
    logic                r_tx,    w_tx_next;
    logic                r_busy,  w_busy_next;
    logic                r_done,  w_done_next;
    logic [7:0]          w_next_byte;
    logic                w_bit_end;

    assign w_bit_end = (r_baud == c_baud_max);

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit;
        w_bytes_next = r_bytes;
        w_shift_next = r_shift;
        w_done_next  = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_START;
                    w_shift_next = result;
                    w_bytes_next = size;
                    w_baud_next  = '0;
                    w_bit_next   = '0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_baud_next  = '0;
                    w_bit_next   = '0;
                    w_state_next = S_DATA;
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_baud_next = '0;
                    if (r_bit == 3'd7) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_next = r_bit + 1'b1;
                    end
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_baud_next = '0;
                    if (r_bytes != 2'd0) begin
                        // Next frame starts immediately on the following byte
                        w_shift_next = {8'h00, r_shift[31:8]};
                        w_bytes_next = r_bytes - 1'b1;
                        w_state_next = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                        w_done_next  = 1'b1;
                    end
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // tx is decoded from the next state so the flop holds the bit for the cycle being entered
    assign w_next_byte = w_shift_next[7:0];

    always_comb begin
        w_tx_next = 1'b1;
        unique case (w_state_next)
            S_IDLE:  w_tx_next = 1'b1;
            S_START: w_tx_next = 1'b0;
            S_DATA:  w_tx_next = w_next_byte[w_bit_next];
            S_STOP:  w_tx_next = 1'b1;
            default: w_tx_next = 1'b1;
        endcase
    end

    assign w_busy_next = (w_state_next != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_bytes <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_bytes <= w_bytes_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
        end
    end

    assign tx   = r_tx;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_debug_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debug_tx_serializer
//  Description : Waveform-level reference model plus directed literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_debug_tx_serializer;

    localparam int CPB = 4;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] result = 32'h0;
    logic [1:0]  size = 2'd0;
    logic        busy, done, tx;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    debug_tx_serializer #(.CLKS_PER_BIT(CPB)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .result (result),
        .size   (size),
        .busy   (busy),
        .done   (done),
        .tx     (tx)
    );

    // Reference: the full expected line waveform is built when a request is accepted
    logic m_bits [0:4*FRAME-1];
    int   m_rem = 0;
    int   m_len = 0;
    logic m_tx = 1'b1, m_busy = 1'b0, m_done = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_rem = 0; m_tx = 1'b1; m_busy = 1'b0; m_done = 1'b0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
                m_tx = 1'b1; m_busy = 1'b0; m_done = 1'b1;
            end else begin
                m_tx = m_bits[m_len - m_rem]; m_busy = 1'b1; m_done = 1'b0;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                for (int b = 0; b < 4; b++) begin
                    for (int f = 0; f < 10; f++) begin
                        logic fb;
                        if (f == 0)      fb = 1'b0;
                        else if (f == 9) fb = 1'b1;
                        else             fb = result[8*b + f - 1];
                        for (int c = 0; c < CPB; c++) m_bits[b*FRAME + f*CPB + c] = fb;
                    end
                end
                m_len  = (int'(size) + 1) * FRAME;
                m_rem  = m_len;
                m_tx   = m_bits[0];
                m_busy = 1'b1;
            end else begin
                m_tx = 1'b1; m_busy = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("tx",   {31'b0, tx},   {31'b0, m_tx});
            chk("busy", {31'b0, busy}, {31'b0, m_busy});
            chk("done", {31'b0, done}, {31'b0, m_done});
        end
    end

    // mode 1: clear result after acceptance; mode 2: pulse start mid-frame
    task automatic send(input logic [31:0] d, input logic [1:0] s, input int mode,
                        output int lat, output logic [31:0] rx, output logic [9:0] raw0);
        rx = '0; raw0 = '0; lat = -1;
        @(negedge clk); start = 1'b1; result = d; size = s;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (mode == 1 && c == 10) result = 32'h0;
            if (mode == 2 && c == 15) begin start = 1'b1; result = 32'hFF; end
            if (mode == 2 && c == 16) start = 1'b0;
            if (c % CPB == 2) begin
                int fr, fb;
                fr = c / FRAME;
                fb = (c / CPB) % 10;
                if (fr == 0) raw0[fb] = tx;
                if (fb >= 1 && fb <= 8 && fr < 4) rx[8*fr + fb - 1] = tx;
            end
            if (done) begin lat = c; break; end
            @(negedge clk);
        end
    endtask

    initial begin
        int          lat;
        logic [31:0] rx;
        logic [9:0]  raw;
        int          nd, d1, d2;

        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_tx",   {31'b0, tx},   32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        send(32'h000000A5, 2'd0, 0, lat, rx, raw);
        chk("a5_raw",  {22'b0, raw}, {22'b0, 10'b1101001010});
        chk("a5_byte", rx,  32'h000000A5);
        chk("a5_lat",  lat, 40);
        repeat (3) @(negedge clk);

        send(32'h12345678, 2'd3, 0, lat, rx, raw);
        chk("w4_bytes", rx,  32'h12345678);
        chk("w4_lat",   lat, 160);
        repeat (3) @(negedge clk);

        send(32'hDEADBEEF, 2'd1, 1, lat, rx, raw);
        chk("w2_bytes", rx,  32'h0000BEEF);
        chk("w2_lat",   lat, 80);
        repeat (3) @(negedge clk);

        send(32'h0000003C, 2'd0, 2, lat, rx, raw);
        chk("ign_byte", rx,  32'h0000003C);
        chk("ign_lat",  lat, 40);
        repeat (5) @(negedge clk);
        chk("ign_tx_idle", {31'b0, tx}, 32'd1);

        // Reset during data bit 3 of the first frame of a 4-byte send
        @(negedge clk); start = 1'b1; result = 32'h12345678; size = 2'd3;
        @(negedge clk); start = 1'b0;
        repeat (17) @(negedge clk);
        chk("pre_rst_busy", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_tx",   {31'b0, tx},   32'd1);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        reset = 1'b0;
        nd = 0;
        repeat (200) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("mid_rst_no_done", nd, 0);
        send(32'h0000005A, 2'd0, 0, lat, rx, raw);
        chk("fresh_byte", rx,  32'h0000005A);
        chk("fresh_lat",  lat, 40);
        repeat (3) @(negedge clk);

        // Start held high: done-to-done spacing is one frame plus one idle cycle
        @(negedge clk); start = 1'b1; result = 32'h00000081; size = 2'd0;
        d1 = -1; d2 = -1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (done) begin
                if (d1 < 0) d1 = t;
                else begin d2 = t; break; end
            end
        end
        start = 1'b0;
        chk("b2b_gap", d2 - d1, 41);
        repeat (60) @(negedge clk);
        chk("b2b_idle_tx", {31'b0, tx}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
